serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: accepts a, b, bin in IDLE, resolves one bit per clock
// LSB first, then presents d/bout in DONE until the downstream handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned     CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] w_d_next;
  logic [CW-1:0]    r_cnt;
  logic             r_brw;
  logic             r_bout;
  logic             w_diff;
  logic             w_brw_next;
  logic             w_last;

  assign w_last     = (r_cnt == LAST);
  assign w_diff     = r_a[0] ^ r_b[0] ^ r_brw;
  assign w_brw_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);

  // Shift-then-insert keeps WIDTH=1 legal without a zero-width slice.
  always_comb begin
    w_d_next            = r_d >> 1;
    w_d_next[WIDTH-1]   = w_diff;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_brw  <= 1'b0;
      r_bout <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_brw <= bin;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_d   <= w_d_next;
          r_brw <= w_brw_next;
          // Counter parks on LAST so it never wraps; the next accept clears it.
          if (w_last) r_bout <= w_brw_next;
          else        r_cnt  <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign d         = r_d;
  assign bout      = r_bout;

endmodule
